// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, reset PC,
// BTB entry field widths, the packed bus layouts and the 2-bit counter helper.
package if_stage_pkg;

    localparam int IF_TO_ID_BUS_WIDTH = 97;
    localparam int ID_TO_IF_BUS_WIDTH = 101;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c000000;

    localparam int BTB_CTR_W    = 2;
    localparam int BTB_TARGET_W = 32;

    typedef logic [BTB_CTR_W-1:0] ctr_t;

    // Counter values given to a freshly allocated entry.
    localparam ctr_t CTR_ALLOC_UNCOND = 2'b11;
    localparam ctr_t CTR_ALLOC_COND   = 2'b10;

    typedef struct packed {
        logic        pred_br_taken;
        logic [31:0] pred_next_pc;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_to_id_t;

    typedef struct packed {
        logic        mispredict;
        logic [31:0] actual_next_pc;
        logic        upd_en;
        logic [31:0] upd_pc;
        logic        is_branch;
        logic        is_cond;
        logic        br_taken;
        logic [BTB_TARGET_W-1:0] br_target;
    } id_to_if_t;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic ctr_t ctrNext(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/if_stage_btb.sv
// Direct-mapped branch target buffer with a combinational lookup port and an
// update port written at the clock edge. Storage exists only when BTB_EN is
// defined; otherwise the lookup always reports not-taken.
module if_stage_btb
    import if_stage_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_lookup_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_is_cond,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target
);

`ifdef BTB_EN
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - 2 - IDX_W;

    logic [ENTRIES-1:0]      r_valid;
    logic [ENTRIES-1:0]      r_uncond;
    logic [TAG_W-1:0]        r_tag    [ENTRIES];
    logic [BTB_TARGET_W-1:0] r_target [ENTRIES];
    ctr_t                    r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [3:0]       w_unused_bits;

    assign w_lk_idx = i_lookup_pc[2 +: IDX_W];
    assign w_lk_tag = i_lookup_pc[31 -: TAG_W];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign o_pred_taken  = w_lk_hit && (r_uncond[w_lk_idx] || r_ctr[w_lk_idx][1]);
    assign o_pred_target = r_target[w_lk_idx];

    assign w_up_idx = i_upd_pc[2 +: IDX_W];
    assign w_up_tag = i_upd_pc[31 -: TAG_W];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign w_unused_bits = {i_lookup_pc[1:0], i_upd_pc[1:0]};

    // Valid bits: cleared by reset, set on an allocating or refreshing update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_upd_valid && (w_up_hit || i_upd_taken)) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Entry payload: a hit trains the counter, a taken miss overwrites the slot.
    always_ff @(posedge clk) begin
        if (i_upd_valid) begin
            if (w_up_hit) begin
                r_target[w_up_idx] <= i_upd_target;
                r_ctr[w_up_idx]    <= ctrNext(r_ctr[w_up_idx], i_upd_taken);
                r_uncond[w_up_idx] <= !i_upd_is_cond;
            end else if (i_upd_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= i_upd_target;
                r_ctr[w_up_idx]    <= i_upd_is_cond ? CTR_ALLOC_COND : CTR_ALLOC_UNCOND;
                r_uncond[w_up_idx] <= !i_upd_is_cond;
            end
        end
    end
`else
    localparam int UNUSED_ENTRIES = ENTRIES;

    logic w_unused_all;

    assign o_pred_taken  = 1'b0;
    assign o_pred_target = '0;
    assign w_unused_all  = ^{clk, reset, i_lookup_pc, i_upd_valid, i_upd_pc,
                             i_upd_is_cond, i_upd_taken, i_upd_target};
`endif

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, the IF->ID valid/ready handshake
// and the hold buffer that keeps a stalled instruction stable while SRAM data
// moves on. Branch prediction comes from if_stage_btb, active when BTB_EN is
// defined; without it the stage always predicts fall-through.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_allow_in,
    output logic                          if_to_id_valid,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
    input  logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus,
    output logic                          inst_sram_en,
    output logic [31:0]                   inst_sram_addr,
    input  logic [31:0]                   inst_sram_rdata
);

    id_to_if_t   w_id;
    if_to_id_t   w_out;

    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_inst_buf_valid;
    logic [31:0] r_inst_buf;

    logic        w_fs_allowin;
    logic        w_fetch;
    logic        w_stall;
    logic        w_pred_taken;
    logic [31:0] w_btb_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_pred_next_pc;
    logic [31:0] w_next_pc;

    assign w_id = id_to_if_bus;

    assign w_fs_allowin = !r_fs_valid || id_allow_in;
    assign w_fetch      = !reset && (w_fs_allowin || w_id.mispredict);
    assign w_stall      = r_fs_valid && !id_allow_in && !w_id.mispredict;

    assign w_seq_pc       = r_fs_pc + 32'd4;
    assign w_pred_next_pc = w_pred_taken ? w_btb_target : w_seq_pc;
    assign w_next_pc      = w_id.mispredict ? w_id.actual_next_pc :
                            r_fs_valid      ? w_pred_next_pc      : RESET_PC;

    if_stage_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .i_lookup_pc   (r_fs_pc),
        .o_pred_taken  (w_pred_taken),
        .o_pred_target (w_btb_target),
        .i_upd_valid   (w_id.upd_en && w_id.is_branch),
        .i_upd_pc      (w_id.upd_pc),
        .i_upd_is_cond (w_id.is_cond),
        .i_upd_taken   (w_id.br_taken),
        .i_upd_target  (w_id.br_target)
    );

    // Fetch PC and valid advance on every issued fetch, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            r_fs_pc    <= RESET_PC;
        end else if (w_fetch) begin
            r_fs_valid <= 1'b1;
            r_fs_pc    <= w_next_pc;
        end
    end

    // Capture SRAM data on the first stall cycle; drop it whenever a new fetch issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_buf_valid <= 1'b0;
        end else if (w_fetch) begin
            r_inst_buf_valid <= 1'b0;
        end else if (w_stall && !r_inst_buf_valid) begin
            r_inst_buf_valid <= 1'b1;
            r_inst_buf       <= inst_sram_rdata;
        end
    end

    assign w_out.pred_br_taken = w_pred_taken;
    assign w_out.pred_next_pc  = w_pred_next_pc;
    assign w_out.pc            = r_fs_pc;
    assign w_out.inst          = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;

    assign if_to_id_bus   = w_out;
    assign if_to_id_valid = r_fs_valid;
    assign inst_sram_en   = w_fetch;
    assign inst_sram_addr = w_next_pc;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a vector table covers sequential fetch,
// stall with hold buffer and redirect; hand sequences cover BTB training,
// counter saturation and reset in mid-stall. A scoreboard queue holds the
// PC/instruction expected for every fetch issued.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST = 32'h1c000000;
`ifdef BTB_EN
    localparam logic BTB = 1'b1;
`else
    localparam logic BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus;
    id_to_if_t   idBus;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [31:0] memData;
    logic        corrupt;
    if_to_id_t   outBus;

    typedef struct packed {
        logic        allow;
        logic        misp;
        logic [31:0] anpc;
        logic        corrupt;
        logic        updEn;
        logic        isBr;
        logic        isCond;
        logic        brTaken;
        logic [31:0] updPc;
        logic [31:0] brTarget;
        logic        expEn;
        logic [31:0] expAddr;
        logic        expValid;
        logic        chkPred;
        logic        expTaken;
        logic [31:0] expNext;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    sb_t  sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    vec_t tbl[12];

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_allow_in     (id_allow_in),
        .if_to_id_valid  (if_to_id_valid),
        .if_to_id_bus    (if_to_id_bus),
        .id_to_if_bus    (idBus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ 32'h5a5af00f;
    endfunction

    // Synchronous SRAM: data for the address presented with en=1 appears next cycle.
    always @(posedge clk) begin
        if (inst_sram_en) memData <= pattern(inst_sram_addr);
    end

    assign inst_sram_rdata = corrupt ? 32'hdeadbeef : memData;
    assign outBus          = if_to_id_bus;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic allow, input logic misp, input logic [31:0] anpc,
                                input logic corr, input logic expEn, input logic [31:0] expAddr,
                                input logic expValid, input logic [31:0] expPc);
        vec_t v;
        v          = '0;
        v.allow    = allow;
        v.misp     = misp;
        v.anpc     = anpc;
        v.corrupt  = corr;
        v.expEn    = expEn;
        v.expAddr  = expAddr;
        v.expValid = expValid;
        v.chkPred  = expValid;
        v.expTaken = 1'b0;
        v.expNext  = expPc + 32'd4;
        return v;
    endfunction

    // One cycle: drive at negedge, check combinational outputs, run scoreboard.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        reset                = 1'b0;
        id_allow_in          = v.allow;
        corrupt              = v.corrupt;
        idBus                = '0;
        idBus.mispredict     = v.misp;
        idBus.actual_next_pc = v.anpc;
        idBus.upd_en         = v.updEn;
        idBus.upd_pc         = v.updPc;
        idBus.is_branch      = v.isBr;
        idBus.is_cond        = v.isCond;
        idBus.br_taken       = v.brTaken;
        idBus.br_target      = v.brTarget;
        #1;
        checkOutput({tag, ".valid"}, {31'b0, if_to_id_valid}, {31'b0, v.expValid});
        checkOutput({tag, ".en"}, {31'b0, inst_sram_en}, {31'b0, v.expEn});
        if (v.expEn) checkOutput({tag, ".addr"}, inst_sram_addr, v.expAddr);
        if (if_to_id_valid) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL %s.sb: got valid output, expected no instruction in flight", tag);
            end else begin
                checkOutput({tag, ".pc"}, outBus.pc, sbq[0].pc);
                checkOutput({tag, ".inst"}, outBus.inst, sbq[0].inst);
                if (v.chkPred) begin
                    checkOutput({tag, ".ptaken"}, {31'b0, outBus.pred_br_taken}, {31'b0, v.expTaken});
                    checkOutput({tag, ".pnext"}, outBus.pred_next_pc, v.expNext);
                end
                if (v.allow || v.misp) void'(sbq.pop_front());
            end
        end
        if (v.expEn) begin
            sb_t e;
            e.pc   = v.expAddr;
            e.inst = pattern(v.expAddr);
            sbq.push_back(e);
        end
    endtask

    // Hold reset for two edges and check the quiet outputs after each.
    task automatic doReset(input string tag);
        @(negedge clk);
        reset       = 1'b1;
        id_allow_in = 1'b1;
        corrupt     = 1'b0;
        idBus       = '0;
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput({tag, ".valid"}, {31'b0, if_to_id_valid}, 32'd0);
            checkOutput({tag, ".en"}, {31'b0, inst_sram_en}, 32'd0);
        end
        sbq.delete();
    endtask

    // Stall cycle carrying a BTB update.
    task automatic doUpdate(input logic [31:0] pc, input logic isBr, input logic isCond,
                            input logic taken, input logic [31:0] target, input string tag);
        vec_t v;
        v          = '0;
        v.updEn    = 1'b1;
        v.isBr     = isBr;
        v.isCond   = isCond;
        v.brTaken  = taken;
        v.updPc    = pc;
        v.brTarget = target;
        v.expValid = 1'b1;
        applyStimulus(v, tag);
    endtask

    // Redirect to pc, then check the prediction made while pc sits in IF.
    task automatic fetchAt(input logic [31:0] pc, input logic expTaken,
                           input logic [31:0] expNext, input string tag);
        vec_t v;
        v          = '0;
        v.allow    = 1'b1;
        v.misp     = 1'b1;
        v.anpc     = pc;
        v.expEn    = 1'b1;
        v.expAddr  = pc;
        v.expValid = 1'b1;
        applyStimulus(v, {tag, ".redir"});
        v          = '0;
        v.allow    = 1'b1;
        v.expEn    = 1'b1;
        v.expAddr  = expNext;
        v.expValid = 1'b1;
        v.chkPred  = 1'b1;
        v.expTaken = expTaken;
        v.expNext  = expNext;
        applyStimulus(v, {tag, ".pred"});
    endtask

    initial begin
        reset       = 1'b1;
        id_allow_in = 1'b0;
        corrupt     = 1'b0;
        idBus       = '0;

        tbl[0]  = mk(1, 0, 0,               0, 1, RST,           0, 0);
        tbl[1]  = mk(1, 0, 0,               0, 1, RST + 32'h4,   1, RST);
        tbl[2]  = mk(1, 0, 0,               0, 1, RST + 32'h8,   1, RST + 32'h4);
        tbl[3]  = mk(0, 0, 0,               0, 0, 0,             1, RST + 32'h8);
        tbl[4]  = mk(0, 0, 0,               1, 0, 0,             1, RST + 32'h8);
        tbl[5]  = mk(0, 0, 0,               1, 0, 0,             1, RST + 32'h8);
        tbl[6]  = mk(1, 0, 0,               1, 1, RST + 32'hc,   1, RST + 32'h8);
        tbl[7]  = mk(1, 0, 0,               0, 1, RST + 32'h10,  1, RST + 32'hc);
        tbl[8]  = mk(0, 0, 0,               0, 0, 0,             1, RST + 32'h10);
        tbl[9]  = mk(0, 1, RST + 32'h100,   0, 1, RST + 32'h100, 1, RST + 32'h10);
        tbl[10] = mk(1, 0, 0,               0, 1, RST + 32'h104, 1, RST + 32'h100);
        tbl[11] = mk(1, 0, 0,               0, 1, RST + 32'h108, 1, RST + 32'h104);

        doReset("reset");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        doUpdate(RST + 32'h10, 1, 0, 1, RST + 32'h40, "upd_uncond");
        fetchAt(RST + 32'h10, BTB, BTB ? RST + 32'h40 : RST + 32'h14, "uncond");

        doUpdate(RST + 32'h20, 1, 1, 1, RST + 32'h80, "upd_c_t");
        fetchAt(RST + 32'h20, BTB, BTB ? RST + 32'h80 : RST + 32'h24, "cond_t1");
        doUpdate(RST + 32'h20, 1, 1, 0, RST + 32'h80, "upd_c_n1");
        fetchAt(RST + 32'h20, 0, RST + 32'h24, "cond_n1");
        doUpdate(RST + 32'h20, 1, 1, 0, RST + 32'h80, "upd_c_n2");
        fetchAt(RST + 32'h20, 0, RST + 32'h24, "cond_n2");
        doUpdate(RST + 32'h20, 1, 1, 0, RST + 32'h80, "upd_c_n3");
        doUpdate(RST + 32'h20, 1, 1, 1, RST + 32'h80, "upd_c_t2");
        fetchAt(RST + 32'h20, 0, RST + 32'h24, "sat_low");

        doUpdate(RST + 32'h30, 0, 0, 1, RST + 32'h90, "upd_nobr");
        fetchAt(RST + 32'h30, 0, RST + 32'h34, "nobranch");
        doUpdate(RST + 32'h50, 1, 1, 0, RST + 32'ha0, "upd_ntmiss");
        fetchAt(RST + 32'h50, 0, RST + 32'h54, "ntmiss");
        fetchAt(RST + 32'h10, BTB, BTB ? RST + 32'h40 : RST + 32'h14, "recheck");

        applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, BTB ? RST + 32'h40 : RST + 32'h14), "prestall");
        doReset("midreset");
        applyStimulus(mk(1, 0, 0, 0, 1, RST,         0, 0),   "rel0");
        applyStimulus(mk(1, 0, 0, 0, 1, RST + 32'h4, 1, RST), "rel1");
        fetchAt(RST + 32'h10, 0, RST + 32'h14, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
